// File: rtl/inst_sched_pkg.sv
// Shared types and default sizing for the instance round-robin scheduler.
package inst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2
  } sched_state_e;

  localparam int NUM_REQ_DEF  = 10;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/inst_rr_scheduler_rr_pick.sv
// Combinational rotating-priority picker: lowest asserted req index at or above ptr, wrapping.
module rr_pick
  import inst_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  localparam int DW = 2 * NUM_REQ;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;
  logic [ID_W:0] pos;

  // The upper copy of req catches requesters below ptr, giving the wrap-around.
  assign dbl    = {req, req};
  assign masked = dbl & ({DW{1'b1}} << ptr);

  always_comb begin
    pos = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (masked[i]) pos = (ID_W + 1)'(i);
    end
  end

  assign found = |req;
  assign idx   = (pos >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(pos - (ID_W + 1)'(NUM_REQ))
                                                : pos[ID_W-1:0];

endmodule

// File: rtl/inst_rr_scheduler.sv
// Round-robin owner scheduler for the inst_0..inst_N fan-out.
// Define INST_SCHED_TIMEOUT_EN to add the MAX_HOLD grant limit, REVOKE state and timeout pulse.
module inst_rr_scheduler
  import inst_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               timeout
);

  if (NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1) begin : g_param_check
    $error("inst_rr_scheduler: NUM_REQ must be 2..32 and MAX_HOLD >= 1");
  end

  sched_state_e    state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            release_now;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the owner's bits matter; everyone else is ignored while a grant is held.
  assign release_now = done[gnt_id] | ~req[gnt_id];
  assign next_ptr    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef INST_SCHED_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
`ifdef INST_SCHED_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= NUM_REQ'(1) << pick_idx;
            gnt_id   <= pick_idx;
            busy     <= 1'b1;
            state    <= GRANT;
`ifdef INST_SCHED_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            state <= IDLE;
          end
`ifdef INST_SCHED_TIMEOUT_EN
          // A same-cycle release takes precedence over revoking the grant.
          else if (hold_expired) begin
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b1;
            ptr     <= next_ptr;
            state   <= REVOKE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
`ifdef INST_SCHED_TIMEOUT_EN
        REVOKE: begin
          timeout <= 1'b0;
          state   <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Bench for inst_rr_scheduler: directed vector table, hand-written corner sequences, random vs. model.
module tb_inst_rr_scheduler;

  localparam int N  = 10;
  localparam int MH = 4;
  localparam int IW = $clog2(N);
`ifdef INST_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req   = '0;
  logic [N-1:0]  done  = '0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  always #5 clk = ~clk;

  inst_rr_scheduler #(
    .NUM_REQ  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: who owns the resource, how many cycles they have held it, where the search starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_held  = 0;
  bit m_rev   = 1'b0;
  bit m_to    = 1'b0;

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] d;
    logic [N-1:0] g;
    int           id;
    bit           b;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_rev = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    if (m_rev) begin
      m_rev = 1'b0;
      m_to  = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (r[c] && m_owner < 0) begin
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end else if (d[m_owner] || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (TO_EN && m_held == MH) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_rev   = 1'b1;
      m_to    = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_id"}, 32'(gnt_id), 32'(m_last));
    check({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] g, input int id,
                           input bit b, input bit to);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_id"}, 32'(gnt_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // r, d, expected gnt, gnt_id, busy
    tbl[0]  = '{10'h008, 10'h000, 10'h008, 3, 1'b1};
    tbl[1]  = '{10'h008, 10'h000, 10'h008, 3, 1'b1};
    tbl[2]  = '{10'h008, 10'h000, 10'h008, 3, 1'b1};
    tbl[3]  = '{10'h008, 10'h008, 10'h000, 3, 1'b0};
    tbl[4]  = '{10'h080, 10'h000, 10'h080, 7, 1'b1};
    tbl[5]  = '{10'h080, 10'h080, 10'h000, 7, 1'b0};
    tbl[6]  = '{10'h003, 10'h000, 10'h001, 0, 1'b1};
    tbl[7]  = '{10'h003, 10'h001, 10'h000, 0, 1'b0};
    tbl[8]  = '{10'h003, 10'h000, 10'h002, 1, 1'b1};
    tbl[9]  = '{10'h000, 10'h000, 10'h000, 1, 1'b0};
    tbl[10] = '{10'h000, 10'h000, 10'h000, 1, 1'b0};
    tbl[11] = '{10'h3FF, 10'h3FF, 10'h004, 2, 1'b1};
    tbl[12] = '{10'h3FF, 10'h3FB, 10'h004, 2, 1'b1};
    tbl[13] = '{10'h3FB, 10'h000, 10'h000, 2, 1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    check_out("reset", '0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].d);
      check_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].b, 1'b0);
    end

    // Asynchronous reset in the middle of a grant to requester 2.
    step(10'h004, 10'h000);
    check_out("pre_rst", 10'h004, 2, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check_out("async_rst", '0, 0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(10'h3FF, 10'h000);
    check_out("post_rst", 10'h001, 0, 1'b1, 1'b0);

    // Full rotation: every owner releases one cycle after its grant.
    for (int k = 0; k <= 10; k++) begin
      check_out($sformatf("rot%0d_grant", k), N'(1) << (k % N), k % N, 1'b1, 1'b0);
      step(10'h3FF, N'(1) << (k % N));
      check_out($sformatf("rot%0d_idle", k), '0, k % N, 1'b0, 1'b0);
      step(10'h3FF, 10'h000);
    end
    check_out("rot_last", 10'h002, 1, 1'b1, 1'b0);
    step(10'h3FF, 10'h002);

`ifdef INST_SCHED_TIMEOUT_EN
    // Requester 5 never releases: revoked after MH grant cycles, then 6 is next.
    step(10'h020, 10'h000);
    check_out("to_g0", 10'h020, 5, 1'b1, 1'b0);
    for (int c = 1; c < MH; c++) begin
      step(10'h020, 10'h000);
      check_out($sformatf("to_g%0d", c), 10'h020, 5, 1'b1, 1'b0);
    end
    step(10'h060, 10'h000);
    check_out("to_pulse", '0, 5, 1'b0, 1'b1);
    step(10'h060, 10'h000);
    check_out("to_revoke", '0, 5, 1'b0, 1'b0);
    step(10'h060, 10'h000);
    check_out("to_next", 10'h040, 6, 1'b1, 1'b0);
    step(10'h060, 10'h040);

    // Release on the last allowed cycle beats the timeout.
    step(10'h020, 10'h000);
    for (int c = 1; c < MH; c++) step(10'h020, 10'h000);
    check_out("race_last", 10'h020, 5, 1'b1, 1'b0);
    step(10'h020, 10'h020);
    check_out("race_rel", '0, 5, 1'b0, 1'b0);
    step(10'h020, 10'h000);
    check_out("race_idle", 10'h020, 5, 1'b1, 1'b0);
    step(10'h000, 10'h000);
`endif

    // Random traffic against the reference model.
    check_model("rnd_start");
    for (int t = 0; t < 3000; t++) begin
      logic [N-1:0] r;
      logic [N-1:0] d;
      r = req;
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      if ($urandom_range(0, 15) == 0) r = '0;
      d = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      step(r, d);
      check_model($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_rr_scheduler.md
# inst_rr_scheduler

Round-robin scheduler that grants exclusive use of a shared resource to one of `NUM_REQ` sibling sub-instances at a time. It sits in the parent of the `inst_0`..`inst_9` fan-out, alongside the child instances. It arbitrates their requests with a rotating priority pointer, holds each grant until the owner releases it, and optionally revokes grants that exceed a hold limit.

## Interface
- `NUM_REQ`, 10, number of requesters; legal range 2..32.
- `MAX_HOLD`, 16, maximum grant length in cycles when the timeout feature is compiled in; minimum 1.
- `ID_W`, `$clog2(NUM_REQ)`, width of the grant index (derived; do not override).
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `req  in  NUM_REQ`: per-requester request, level-sensitive.
- `done  in  NUM_REQ`: per-requester release strobe; only the bit of the current owner is honoured.
- `gnt  out  NUM_REQ`: one-hot grant, registered.
- `gnt_id  out  ID_W`: index of the current or last owner, registered.
- `busy  out  1`: high while in state GRANT.
- `timeout  out  1`: one-cycle pulse when a grant is revoked (timeout build only; tied 0 otherwise).

## Operation
- **States:** IDLE, GRANT, REVOKE.
- **IDLE:**
  - If `|req` is 0, stay in IDLE.
  - Otherwise pick the first asserted `req` bit scanning upward from `ptr`, wrapping past NUM_REQ-1 to 0.
  - Register `gnt`, `gnt_id` and `busy=1`, then go to GRANT.
- **GRANT:**
  - Release when `done[gnt_id]` = 1 or `req[gnt_id]` = 0 in the same cycle. On release: `gnt`=0, `busy`=0, `ptr`=(`gnt_id`+1) mod NUM_REQ, next state IDLE.
  - `done` and `req` bits of non-owners are ignored while in GRANT.
- **Hold counter** (timeout build only):
  - `hold_cnt` clears on entry to GRANT and increments every cycle spent in GRANT.
  - When `hold_cnt` == MAX_HOLD-1 and no release occurs in that cycle, go to REVOKE: `gnt`=0, `timeout`=1, `ptr`=(`gnt_id`+1) mod NUM_REQ.
- **REVOKE:** lasts exactly one cycle, drops `timeout` to 0, then goes to IDLE. No arbitration happens in REVOKE.
- **Simultaneous release and timeout:** release wins; `timeout` stays 0.
- **Wrap-around:** the pointer wraps from NUM_REQ-1 to 0. `gnt_id` holds its last value while idle.
- **Reset values** (async assert, sync deassert handled by the top level): state IDLE, `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0.
- **Reset during GRANT:** the grant drops immediately and no release or timeout is reported.

## Timing
- Grant latency: `req` sampled in IDLE at cycle t gives `gnt` high at t+1.
- Release latency: `done` at cycle t gives `gnt` low at t+1. The next grant appears no earlier than t+2, because one IDLE cycle always separates owners.
- Timeout: `gnt` high for exactly MAX_HOLD cycles. `timeout` is high in the cycle after the last grant cycle. The next grant appears no earlier than 2 cycles after that.
- Fairness: with all requesters continuously asserting, each one is granted once within every NUM_REQ grants.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `INST_SCHED_TIMEOUT_EN`.
- **Defined:** `hold_cnt`, the REVOKE state and the `timeout` pulse are present, as described above.
- **Undefined:** the counter and REVOKE are removed and `timeout` is tied to 0. Grants last until released by `done` or a dropped `req`, with no upper bound.

## Structure
- Package `inst_sched_pkg` holds:
  - the state enum `sched_state_e` (IDLE, GRANT, REVOKE);
  - the default constants `NUM_REQ_DEF`=10 and `MAX_HOLD_DEF`=16.
- Sub-module `rr_pick` holds the combinational rotating priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
  - Method: double-width masked priority encode.
  - It is reused for any future N-way schedulers in the hierarchy.
- The top level contains the FSM, the pointer, the counter and the output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant with `gnt`=0x004 → all outputs 0 in the same cycle, and `ptr`=0 after release.
- **Single request:** `req`=0x008 at t, `done[3]` at t+3 → `gnt`=0x008 and `gnt_id`=3 for t+1..t+3, `gnt`=0 at t+4.
- **Rotation:** all 10 requests held, each owner pulses `done` one cycle after its grant → grant order 0,1,...,9,0 with one idle cycle between owners.
- **Wrap-around:** `ptr`=8, `req`=0x003 → grant 0 first, then 1.
- **Timeout** (macro defined, MAX_HOLD=4): `req[5]` held with no `done` → `gnt[5]` high 4 cycles, `timeout` pulses the following cycle, and the next grant goes to 6 if it is requesting.
- **Same-cycle release vs timeout:** `done[5]` asserted on the last allowed cycle → `timeout` stays 0 and the next state is IDLE.
